alu_rr_sched: RTL

Round-robin scheduler that shares one 3-bit ALU (add/sub/mul/div) between two requesters. Each requester uses a valid/ready request channel. The block accepts one operation at a time, registers operands, executes on a shared combinational core, and returns the result on a single response channel tagged with the requester ID. It sits between the pin-level input decode and the shared ALU datapath in the tt_um top.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_core.sv | 42 ++++
 rtl/alu_rr_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the round-robin ALU scheduler: opcodes, FSM encodings
// and the divide-by-zero result pattern.
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_MUL = 2'b10;
  localparam alu_op_t OP_DIV = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/alu_core.sv
// Purely combinational shared ALU: zero-extends both operands to RESW and
// computes add/sub/mul/truncating div; divide by zero yields DIV0_RESULT + err.
module alu_core
  import alu_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int RESW = 8
) (
  input  alu_op_t         op_i,
  input  logic [OPW-1:0]  a_i,
  input  logic [OPW-1:0]  b_i,
  output logic [RESW-1:0] result_o,
  output logic            err_o
);

  logic [RESW-1:0] a_ext;
  logic [RESW-1:0] b_ext;

  assign a_ext = RESW'(a_i);
  assign b_ext = RESW'(b_i);

  always_comb begin
    // NOTE: outputs get defaults before the case so no path leaves them unassigned (no latch).
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD: result_o = a_ext + b_ext;
      OP_SUB: result_o = a_ext - b_ext;
      OP_MUL: result_o = a_ext * b_ext;
      OP_DIV: begin
        if (b_i == '0) begin
          result_o = RESW'(DIV0_RESULT);
          err_o    = 1'b1;
        end else begin
          result_o = a_ext / b_ext;
        end
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Two-requester round-robin front end for the shared ALU: grants one op in IDLE,
// executes it for one cycle, then holds the tagged result until it is consumed.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int RESW = 8,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [RESW-1:0] rsp_result,
  output logic            rsp_err,
  output logic            busy,
  output logic [CNTW-1:0] done_cnt
);

  logic [1:0]      state_q, state_d;
  logic            prio_q, prio_d;
  alu_op_t         op_q, op_d;
  logic [OPW-1:0]  a_q, a_d;
  logic [OPW-1:0]  b_q, b_d;
  logic            id_q, id_d;
  logic            rsp_id_q, rsp_id_d;
  logic [RESW-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CNTW-1:0] done_cnt_q, done_cnt_d;

  logic            idle;
  logic            grant0, grant1;
  logic [RESW-1:0] core_result;
  logic            core_err;

  // prio_q names the requester that wins when both are valid.
  assign idle   = (state_q == S_IDLE);
  assign grant0 = idle && ena && req0_valid && (!req1_valid || !prio_q);
  assign grant1 = idle && ena && req1_valid && (!req0_valid ||  prio_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = !idle;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign done_cnt   = done_cnt_q;

  alu_core #(.OPW(OPW), .RESW(RESW)) u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (core_result),
    .err_o    (core_err)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          op_d    = grant1 ? req1_op : req0_op;
          a_d     = grant1 ? req1_a  : req0_a;
          b_d     = grant1 ? req1_b  : req0_b;
          id_d    = grant1;
          prio_d  = !grant1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = core_result;
        rsp_err_d    = core_err;
        rsp_id_d     = id_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          done_cnt_d = done_cnt_q + CNTW'(1);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  // NOTE: operand registers are left unreset; they are always loaded at a grant before EXEC reads them.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
    id_q <= id_d;
  end

endmodule
